// File: rtl/seq_count_pkg.sv
// Shared types for the sequential-counter family (up, down, future up/down).
package seq_count_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   typedef enum logic [2:0] {
      NS_RESET,
      NS_CLR,
      NS_LD,
      NS_INC,
      NS_HOLD
   } ns_sel_e;

endpackage

// File: rtl/seq_count_reg_rst.sv
// W-bit register with synchronous active-high reset to zero.
module seq_count_reg_rst #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/seq_count_nb_bin_up_ctrl.sv
// Binary up counter with clear, clamped parallel load, terminal value and
// wrap/saturate mode; tc flags the enabled cycle sitting at the terminal value.
module seq_count_nb_bin_up_ctrl
   import seq_count_pkg::*;
#(
   parameter int unsigned NBITS   = 3,
   parameter int unsigned MAXVAL  = (1 << NBITS) - 1,
   parameter int unsigned SATMODE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [NBITS-1:0] ld_val,
   output logic [NBITS-1:0] out,
   output logic             tc,
   output logic             ovf
);

   localparam int unsigned    CW    = NBITS + 1;
   localparam logic [NBITS-1:0] MAX_C = NBITS'(MAXVAL);
   localparam cnt_mode_e      MODE  = (SATMODE != 0) ? CNT_SAT : CNT_WRAP;

   ns_sel_e          ns_sel;
   logic [NBITS-1:0] cnt_q;
   logic [NBITS-1:0] cnt_d;
   logic [NBITS-1:0] ld_clamped;
   logic [CW-1:0]    inc_sum;
   logic             carry_unused;
   logic             at_max;
   logic             ovf_d;

   assign at_max       = (cnt_q == MAX_C);
   assign inc_sum      = {1'b0, cnt_q} + CW'(1);
   assign carry_unused = inc_sum[NBITS];
   assign ld_clamped   = (ld_val > MAX_C) ? MAX_C : ld_val;

   // Priority select: reset > clr > ld > en > hold.
   always_comb begin
      ns_sel = NS_HOLD;
      if (reset)    ns_sel = NS_RESET;
      else if (clr) ns_sel = NS_CLR;
      else if (ld)  ns_sel = NS_LD;
      else if (en)  ns_sel = NS_INC;
   end

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf;
      unique case (ns_sel)
         NS_RESET,
         NS_CLR: begin
            cnt_d = '0;
            ovf_d = 1'b0;
         end
         NS_LD: cnt_d = ld_clamped;
         NS_INC: begin
            if (!at_max) begin
               cnt_d = inc_sum[NBITS-1:0];
            end else begin
               cnt_d = (MODE == CNT_SAT) ? MAX_C : '0;
               ovf_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   seq_count_reg_rst #(
      .W (NBITS)
   ) u_cnt_reg (
      .clk   (clk),
      .reset (reset),
      .d     (cnt_d),
      .q     (cnt_q)
   );

   always_ff @(posedge clk) begin
      if (reset) ovf <= 1'b0;
      else       ovf <= ovf_d;
   end

   assign out = cnt_q;
   assign tc  = (ns_sel == NS_INC) && at_max;

endmodule
